// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - unified memory arbiter between the multicycle core and an external port
// CPU wins by default; a wait counter forces external grants and ext_lock sustains bounded bursts.
module mem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAXWAIT  = 4,
  parameter int MAXBURST = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic             ext_lock,
  input  logic [WIDTH-1:0] ext_addr,
  input  logic [WIDTH-1:0] ext_wdata,
  output logic [WIDTH-1:0] ext_rdata,
  output logic             ext_ack,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [1:0]       owner
);

  localparam int WW = $clog2(MAXWAIT + 1);
  localparam int BW = $clog2(MAXBURST + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAXWAIT);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAXBURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_EXT  = 2'b10
  } owner_e;

  owner_e        owner_q;
  owner_e        grant;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_cnt_d;
  logic [BW-1:0] burst_cnt;
  logic [BW-1:0] burst_cnt_d;
  logic          burst_cont;
  logic          ext_win;

  // Grant is gated by reset so the memory sees no access while reset is held.
  always_comb begin
    grant      = OWN_NONE;
    burst_cont = (owner_q == OWN_EXT) && ext_req && ext_lock && (burst_cnt < BURST_MAX);
    ext_win    = ext_req && (!cpu_req || (wait_cnt == WAIT_MAX));
    if (!reset) begin
      grant = OWN_NONE;
    end else if (burst_cont || ext_win) begin
      grant = OWN_EXT;
    end else if (cpu_req) begin
      grant = OWN_CPU;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (grant)
      OWN_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      OWN_EXT: begin
        mem_we    = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;
  assign cpu_stall = cpu_req && (grant != OWN_CPU);
  assign ext_ack   = (grant == OWN_EXT);
  assign owner     = owner_q;

  // Both counters saturate; a denied-but-waiting external port is the only thing that ages wait_cnt.
  always_comb begin
    wait_cnt_d  = '0;
    burst_cnt_d = '0;
    if (ext_req && (grant != OWN_EXT)) begin
      wait_cnt_d = (wait_cnt == WAIT_MAX) ? WAIT_MAX : wait_cnt + 1'b1;
    end
    if (grant == OWN_EXT) begin
      burst_cnt_d = (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_NONE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      owner_q   <= grant;
      wait_cnt  <= wait_cnt_d;
      burst_cnt <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Directed scenarios plus randomized traffic against a rule-level grant model.
module tb_mem_arbiter;

  localparam int WIDTH    = 32;
  localparam int MAXWAIT  = 4;
  localparam int MAXBURST = 8;

  logic             clk;
  logic             reset;
  logic             cpu_req, cpu_we;
  logic [WIDTH-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic             cpu_stall;
  logic             ext_req, ext_we, ext_lock;
  logic [WIDTH-1:0] ext_addr, ext_wdata, ext_rdata;
  logic             ext_ack;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]       owner;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] tbmem   [256];
  logic [WIDTH-1:0] ref_mem [256];

  int m_owner, m_waited, m_burst;

  mem_arbiter #(.WIDTH(WIDTH), .MAXWAIT(MAXWAIT), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = tbmem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;

  // Expected grant for the current inputs: 0 none, 1 CPU, 2 external.
  function automatic int model_grant();
    if (!reset) return 0;
    if (m_owner == 2 && ext_req && ext_lock && m_burst < MAXBURST) return 2;
    if (ext_req && (!cpu_req || m_waited == MAXWAIT)) return 2;
    if (cpu_req) return 1;
    return 0;
  endfunction

  task automatic assert_reset();
    reset    = 1'b0;
    m_owner  = 0;
    m_waited = 0;
    m_burst  = 0;
  endtask

  task automatic tick();
    int g;
    g = model_grant();
    @(posedge clk);
    if (!reset) begin
      m_owner = 0; m_waited = 0; m_burst = 0;
    end else begin
      if (g == 1 && cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
      if (g == 2 && ext_we) ref_mem[ext_addr[7:0]] = ext_wdata;
      m_owner  = g;
      m_burst  = (g == 2) ? ((m_burst < MAXBURST) ? m_burst + 1 : MAXBURST) : 0;
      m_waited = (ext_req && g != 2) ? ((m_waited < MAXWAIT) ? m_waited + 1 : MAXWAIT) : 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    assert_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    assert_reset();
    cpu_req = 1; ext_req = 1;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (ext_ack !== 1'b0) begin failures++; $display("FAIL reset_ext_ack got=%b exp=0", ext_ack); end
    checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL reset_cpu_stall got=%b exp=1", cpu_stall); end
    tick();
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL reset_owner got=%b exp=00", owner); end
    reset = 1'b1;
    tick();
    checks++; if (owner !== 2'b01) begin failures++; $display("FAIL reset_release_owner got=%b exp=01", owner); end
  endtask

  task automatic test_uncontended_cpu();
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL unc_stall got=%b exp=0", cpu_stall); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL unc_mem_we got=%b exp=1", mem_we); end
    checks++; if (mem_addr !== 32'h40) begin failures++; $display("FAIL unc_mem_addr got=%h exp=40", mem_addr); end
    tick();
    cpu_we = 0; cpu_wdata = '0;
    @(negedge clk);
    checks++; if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL unc_rdata got=%h exp=deadbeef", cpu_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    cpu_req = 1; ext_req = 1; ext_lock = 0; cpu_addr = 32'h4;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (ext_ack !== (k % 5 == 0)) begin
        failures++; $display("FAIL starve_ack cycle=%0d got=%b exp=%b", k, ext_ack, (k % 5 == 0));
      end
      checks++;
      if (cpu_stall !== (k % 5 == 0)) begin
        failures++; $display("FAIL starve_stall cycle=%0d got=%b exp=%b", k, cpu_stall, (k % 5 == 0));
      end
      tick();
    end
  endtask

  task automatic test_burst();
    do_reset();
    cpu_req = 1; ext_req = 1; ext_lock = 1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if (ext_ack !== (k >= 5 && k <= 12)) begin
        failures++; $display("FAIL burst_ack cycle=%0d got=%b exp=%b", k, ext_ack, (k >= 5 && k <= 12));
      end
      if (k == 13) begin
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL burst_end_stall got=%b exp=0", cpu_stall); end
      end
      tick();
    end
  endtask

  task automatic test_ext_only();
    logic [WIDTH-1:0] d;
    do_reset();
    d = $urandom;
    ext_req = 1; ext_lock = 0; ext_we = 1; ext_addr = 32'h10; ext_wdata = d;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (ext_ack !== 1'b1) begin failures++; $display("FAIL ext_only_ack cycle=%0d got=%b exp=1", k, ext_ack); end
      if (k >= 2) begin
        checks++; if (owner !== 2'b10) begin failures++; $display("FAIL ext_only_owner cycle=%0d got=%b exp=10", k, owner); end
        checks++; if (ext_rdata !== d) begin failures++; $display("FAIL ext_only_rdata got=%h exp=%h", ext_rdata, d); end
      end
      tick();
      ext_we = 0;
    end
    cpu_req = 1;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL ext_only_cpu_stall got=%b exp=0", cpu_stall); end
    checks++; if (ext_ack !== 1'b0) begin failures++; $display("FAIL ext_only_cpu_ack got=%b exp=0", ext_ack); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    cpu_req = 1; ext_req = 1; ext_lock = 1;
    for (int k = 1; k <= 6; k++) tick();
    @(negedge clk);
    checks++; if (ext_ack !== 1'b1) begin failures++; $display("FAIL midburst_pre_ack got=%b exp=1", ext_ack); end
    #1;
    assert_reset();
    #1;
    checks++; if (ext_ack !== 1'b0) begin failures++; $display("FAIL midburst_ack got=%b exp=0", ext_ack); end
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL midburst_owner got=%b exp=00", owner); end
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL midburst_release_stall got=%b exp=0", cpu_stall); end
    checks++; if (ext_ack !== 1'b0) begin failures++; $display("FAIL midburst_release_ack got=%b exp=0", ext_ack); end
    tick();
  endtask

  task automatic test_random();
    int g;
    int prev_g;
    do_reset();
    prev_g = 0;
    for (int n = 0; n < 600; n++) begin
      if (!(cpu_req && prev_g != 1)) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = ($urandom_range(0, 2) == 0);
        cpu_addr  = WIDTH'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      ext_req   = ($urandom_range(0, 2) != 0);
      ext_lock  = ($urandom_range(0, 1) == 1);
      ext_we    = ($urandom_range(0, 3) == 0);
      ext_addr  = WIDTH'($urandom_range(0, 15));
      ext_wdata = $urandom;
      if ($urandom_range(0, 59) == 0) assert_reset();
      else reset = 1'b1;
      @(negedge clk);
      g = model_grant();
      checks++; if (ext_ack !== (g == 2)) begin failures++; $display("FAIL rnd_ext_ack n=%0d got=%b exp=%b", n, ext_ack, (g == 2)); end
      checks++; if (cpu_stall !== (cpu_req && g != 1)) begin failures++; $display("FAIL rnd_cpu_stall n=%0d got=%b exp=%b", n, cpu_stall, (cpu_req && g != 1)); end
      checks++; if (owner !== 2'(m_owner)) begin failures++; $display("FAIL rnd_owner n=%0d got=%b exp=%0d", n, owner, m_owner); end
      checks++;
      if (mem_we !== ((g == 1 && cpu_we) || (g == 2 && ext_we))) begin
        failures++; $display("FAIL rnd_mem_we n=%0d got=%b grant=%0d", n, mem_we, g);
      end
      checks++;
      if (mem_addr !== ((g == 1) ? cpu_addr : (g == 2) ? ext_addr : '0)) begin
        failures++; $display("FAIL rnd_mem_addr n=%0d got=%h grant=%0d", n, mem_addr, g);
      end
      checks++;
      if (mem_wdata !== ((g == 1) ? cpu_wdata : (g == 2) ? ext_wdata : '0)) begin
        failures++; $display("FAIL rnd_mem_wdata n=%0d got=%h grant=%0d", n, mem_wdata, g);
      end
      if (g == 1 && !cpu_we) begin
        checks++;
        if (cpu_rdata !== ref_mem[cpu_addr[7:0]]) begin
          failures++; $display("FAIL rnd_cpu_rdata n=%0d got=%h exp=%h", n, cpu_rdata, ref_mem[cpu_addr[7:0]]);
        end
      end
      if (g == 2 && !ext_we) begin
        checks++;
        if (ext_rdata !== ref_mem[ext_addr[7:0]]) begin
          failures++; $display("FAIL rnd_ext_rdata n=%0d got=%h exp=%h", n, ext_rdata, ref_mem[ext_addr[7:0]]);
        end
      end
      prev_g = g;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbmem[i]   = '0;
      ref_mem[i] = '0;
    end
    idle_inputs();
    reset = 1'b1;
    m_owner = 0; m_waited = 0; m_burst = 0;
    #2;
    test_reset();
    test_uncontended_cpu();
    test_starvation();
    test_burst();
    test_ext_only();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single unified instruction/data memory of the multicycle MIPS core between the core's memory port and an external requester (program loader / debug port). The CPU has priority by default. A wait counter prevents starvation of the external port, and a lock input allows bounded external bursts. `cpu_stall` feeds the multicycle controller so that it holds its current state, and therefore `pcen`, `irwrite` and `memwrite`, while the CPU is denied the memory.

## Interface
- `WIDTH`, default 32: address and data width.
- `MAXWAIT`, default 4: number of consecutive denied external cycles after which the external port is force-granted.
- `MAXBURST`, default 8: maximum number of consecutive external grants sustained by `ext_lock`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU memory access this cycle, address from the `iord` mux.
- `cpu_we` in 1: CPU write; this is the controller's `memwrite`.
- `cpu_addr` in WIDTH: CPU address.
- `cpu_wdata` in WIDTH: CPU write data.
- `cpu_rdata` out WIDTH: read data to the instruction and data registers.
- `cpu_stall` out 1: CPU denied this cycle.
- `ext_req` in 1: external access request.
- `ext_we` in 1: external write.
- `ext_lock` in 1: request to keep the grant on the next cycle.
- `ext_addr` in WIDTH: external address.
- `ext_wdata` in WIDTH: external write data.
- `ext_rdata` out WIDTH: read data to the external port.
- `ext_ack` out 1: external access performed this cycle.
- `mem_we` out 1: memory write enable.
- `mem_addr` out WIDTH: memory address.
- `mem_wdata` out WIDTH: memory write data.
- `mem_rdata` in WIDTH: combinational read data from memory.
- `owner` out 2: registered owner of the previous cycle; 00 none, 01 CPU, 10 external.

## Operation
- **Memory model.** Memory read is combinational and write occurs on the clock edge. Every granted access completes in the same cycle.
- **Grant decision.** The grant is combinational each cycle. The first matching rule wins:
  1. Burst continuation: `owner`==10, `ext_req`, `ext_lock` and `burst_cnt`<MAXBURST → external.
  2. `ext_req` and (!`cpu_req` or `wait_cnt`==MAXWAIT) → external.
  3. `cpu_req` → CPU.
  4. Otherwise → no grant.
- **Memory-side outputs.**
  - CPU grant: `mem_addr`/`mem_wdata`/`mem_we` driven from the CPU port.
  - External grant: driven from the external port.
  - No grant: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- **Requester-side outputs.**
  - `cpu_rdata` and `ext_rdata` both equal `mem_rdata` unconditionally. Each is meaningful only when its port is granted.
  - `cpu_stall` = `cpu_req` & !CPU grant.
  - `ext_ack` = external grant.
- **`wait_cnt`** (width clog2(MAXWAIT+1)):
  - +1 when `ext_req` is high and the external port is not granted; saturates at MAXWAIT.
  - Cleared when the external port is granted or `ext_req` is low.
- **`burst_cnt`** (width clog2(MAXBURST+1)):
  - +1 on each external grant; saturates at MAXBURST.
  - Cleared on any cycle without an external grant.
- **`owner` register.** Loads the current cycle's grant encoding at each edge.
- **Ignored inputs.** `ext_lock` is ignored when `ext_req` is low. `cpu_we` and `ext_we` are ignored when not granted, so there is never a write from a denied port.

## Timing
- **Reset.** While `reset`=0, asynchronously:
  - `owner`=00, `wait_cnt`=0, `burst_cnt`=0.
  - No grant: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `ext_ack`=0, `cpu_stall`=`cpu_req`.
- **Reset release.** The first edge after release is a normal evaluation.
- **Reset mid-burst.** A burst is abandoned and does not resume; the external port must re-win under rule 2.
- **Grant latency.** Zero cycles: an uncontended request is served in the cycle it is raised.
- **Stall and forced grant.** A stalled CPU holds `cpu_req`/`cpu_addr`/`cpu_we` stable until `cpu_stall` is low.
  - Worst-case external latency under continuous CPU traffic: MAXWAIT+1 cycles (MAXWAIT denials, then a forced grant).
- **Simultaneous requests, counter not saturated.** CPU wins and `wait_cnt` increments.
- **Burst limit.** The grant after the MAXBURST-th consecutive external grant goes to the CPU if `cpu_req` is high.
  - If `cpu_req` is low, the external port keeps winning under rule 2 and `burst_cnt` stays saturated.
- **After a forced or burst-ending external grant.** `wait_cnt` restarts at 0, so the next forced grant is MAXWAIT denials later.
- **Write timing.** A write is committed at the edge ending its granted cycle.

## Test plan
- **Reset.** Hold `reset`=0 with `cpu_req`=1 and `ext_req`=1 → `mem_we`=0, `ext_ack`=0, `cpu_stall`=1, `owner`=00. Release → `owner`=01 after the first edge.
- **Uncontended CPU.** `cpu_req`=1, `cpu_we`=1, `cpu_addr`=0x40, `cpu_wdata`=0xDEADBEEF, `ext_req`=0 → `cpu_stall`=0, `mem_we`=1, `mem_addr`=0x40. A following read of 0x40 returns 0xDEADBEEF on `cpu_rdata`.
- **Starvation guard.** Continuous `cpu_req` and `ext_req`, MAXWAIT=4 → `ext_ack` low for 4 cycles, high on the 5th with `cpu_stall`=1 in that cycle, then low for the next 4.
- **Locked burst.** `cpu_req`=1, `ext_lock`=1, external port just force-granted, MAXBURST=8 → `ext_ack` high for 8 consecutive cycles, then `cpu_stall`=0 on the 9th.
- **External-only traffic.** `ext_req`=1, `ext_lock`=0, `cpu_req`=0 → `ext_ack`=1 every cycle and `owner`=10 from the second cycle. Raise `cpu_req` → CPU granted in that same cycle.
- **Reset mid-burst.** Assert `reset` during the 3rd burst cycle → `ext_ack` drops immediately. After release with `cpu_req`=1 and `ext_req`=1 → CPU wins the first cycle.
